// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// load writeback paths, with r15 routed to a PC strobe and a pending-write scoreboard.
module rf_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  input  logic            claim_valid,
  input  logic [AW-1:0]   claim_addr,
  output logic            we3,
  output logic [AW-1:0]   wa3,
  output logic [DW-1:0]   wd3,
  output logic            pc_we,
  output logic [DW-1:0]   pc_wd,
  output logic [(1<<AW)-2:0] busy
);

  localparam int            NREG    = (1 << AW) - 1;
  localparam logic [AW-1:0] PC_ADDR = '1;

  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } pri_e;

  pri_e            ptr;
  logic            grant0;
  logic            grant1;
  logic            any_grant;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            sel_is_pc;
  logic [NREG-1:0] busy_set;
  logic [NREG-1:0] busy_clr;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || ptr == PRI_REQ0);
    grant1 = req1_valid && (!req0_valid || ptr == PRI_REQ1);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign any_grant  = grant0 || grant1;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;
  assign sel_is_pc  = (sel_addr == PC_ADDR);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_set[i] = claim_valid && (claim_addr == AW'(i));
      busy_clr[i] = we3 && (wa3 == AW'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PRI_REQ0;
    end else if (grant0) begin
      ptr <= PRI_REQ1;
    end else if (grant1) begin
      ptr <= PRI_REQ0;
    end
  end

  // Registered write port; address/data hold when no register write is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
      pc_we <= 1'b0;
      pc_wd <= '0;
    end else begin
      we3   <= any_grant && !sel_is_pc;
      pc_we <= any_grant && sel_is_pc;
      if (any_grant && !sel_is_pc) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
      end
      if (any_grant && sel_is_pc) begin
        pc_wd <= sel_data;
      end
    end
  end

  // A claim landing on the same edge as the commit keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

endmodule
